// File: rtl/isa_pkg.sv
// Shared ISA definitions for the issue stage.
// Instruction layout (32 bits, bits [31:25] unused):
//   [2:0]   opcode   (class decoded from [1:0] only)
//   [7:3]   Rs1
//   [12:8]  Rd
//   [17:13] Rs2      (overlaps the low bits of imm)
//   [24:13] imm
package isa_pkg;

  localparam int unsigned INS_W = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned IMM_W = 12;
  localparam int unsigned OPC_W = 3;

  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned RS1_LSB = 3;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS2_LSB = 13;
  localparam int unsigned IMM_LSB = 13;

  // Highest meaningful instruction bit + 1; bits above this are never looked at.
  localparam int unsigned USED_W = IMM_LSB + IMM_W;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_ADD  = 2'b01,
    OP_MUL  = 2'b10,
    OP_ADDI = 2'b11
  } op_class_e;

  // Class comes from the two low opcode bits; opcode[2] is deliberately ignored.
  function automatic op_class_e op_class(input logic [1:0] opc_lo);
    return op_class_e'(opc_lo);
  endfunction

  // Only the register-register classes read Rs2; ADDI reuses those bits as imm.
  function automatic logic reads_rs2(input op_class_e cls);
    return (cls == OP_ADD) || (cls == OP_MUL);
  endfunction

endpackage

// File: rtl/hazard_sb.sv
// Destination scoreboard for in-flight instructions.
// A PEND-deep shift register of destination registers that advances every cycle,
// mirroring the downstream pipe, plus two source compare ports.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   wr_rd          destination entering the pipe this cycle (0 = nothing owed)
//   rs1, rs1_en    first source and its compare enable
//   rs2, rs2_en    second source and its compare enable
//   hazard         some enabled nonzero source matches a pending destination
module hazard_sb
  import isa_pkg::*;
#(
  parameter int unsigned PEND = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] wr_rd,
  input  logic [REG_W-1:0] rs1,
  input  logic             rs1_en,
  input  logic [REG_W-1:0] rs2,
  input  logic             rs2_en,
  output logic             hazard
);

  logic [REG_W-1:0] sb_q [PEND];
  logic             chk1;
  logic             chk2;

  // Shifts unconditionally: the downstream pipe never stalls, so a bubble
  // simply pushes a 0 entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(PEND); k++) begin
        sb_q[k] <= '0;
      end
    end else begin
      sb_q[0] <= wr_rd;
      for (int k = 1; k < int'(PEND); k++) begin
        sb_q[k] <= sb_q[k-1];
      end
    end
  end

  // R0 is never pending, and empty entries hold 0, so a zero source must not match.
  assign chk1 = rs1_en && (rs1 != '0);
  assign chk2 = rs2_en && (rs2 != '0);

  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < int'(PEND); k++) begin
      if ((chk1 && (rs1 == sb_q[k])) || (chk2 && (rs2 == sb_q[k]))) begin
        hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_stage.sv
// In-order issue stage between fetch and the execute pipes.
// Holds one fetched instruction, splits it into fields and stalls fetch (issuing
// bubbles) while a source register is still pending in the add/multiply pipes.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   ins_in         instruction from fetch
//   ins_valid      ins_in carries a real instruction
//   fetch_stall    fetch must hold PC and ins_in
//   opcode, Rs1, Rs2, Rd, imm
//                  issued fields; all zero for a bubble
//   stall_cycles   saturating count of stalled cycles
module issue_stage
  import isa_pkg::*;
#(
  parameter int unsigned PEND  = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INS_W-1:0] ins_in,
  input  logic             ins_valid,
  output logic             fetch_stall,
  output logic [OPC_W-1:0] opcode,
  output logic [REG_W-1:0] Rs1,
  output logic [REG_W-1:0] Rs2,
  output logic [REG_W-1:0] Rd,
  output logic [IMM_W-1:0] imm,
  output logic [CNT_W-1:0] stall_cycles
);

  logic [USED_W-1:0] ins_q;
  logic              valid_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_d;

  logic [OPC_W-1:0]  f_opc;
  logic [REG_W-1:0]  f_rs1;
  logic [REG_W-1:0]  f_rs2;
  logic [REG_W-1:0]  f_rd;
  logic [IMM_W-1:0]  f_imm;
  op_class_e         cls;

  logic              rs1_en;
  logic              rs2_en;
  logic              hazard;
  logic              issue;
  logic [REG_W-1:0]  sb_wr_rd;

  // Upper instruction bits carry nothing and are not stored.
  logic              unused_ins_hi;
  assign unused_ins_hi = ^ins_in[INS_W-1:USED_W];

  // Field split of the held instruction.
  assign f_opc = ins_q[OPC_LSB +: OPC_W];
  assign f_rs1 = ins_q[RS1_LSB +: REG_W];
  assign f_rd  = ins_q[RD_LSB  +: REG_W];
  assign f_rs2 = ins_q[RS2_LSB +: REG_W];
  assign f_imm = ins_q[IMM_LSB +: IMM_W];
  assign cls   = op_class(f_opc[1:0]);

  assign rs1_en = valid_q && (cls != OP_NOP);
  assign rs2_en = valid_q && reads_rs2(cls);

  hazard_sb #(
    .PEND (PEND)
  ) u_hazard_sb (
    .clk    (clk),
    .rst    (rst),
    .wr_rd  (sb_wr_rd),
    .rs1    (f_rs1),
    .rs1_en (rs1_en),
    .rs2    (f_rs2),
    .rs2_en (rs2_en),
    .hazard (hazard)
  );

  assign issue       = valid_q && !hazard;
  assign fetch_stall = hazard;

  // A NOP owes no write-back even if its Rd field is nonzero.
  assign sb_wr_rd = (issue && (cls != OP_NOP)) ? f_rd : '0;

  always_comb begin
    opcode = '0;
    Rs1    = '0;
    Rs2    = '0;
    Rd     = '0;
    imm    = '0;
    if (issue) begin
      opcode = f_opc;
      Rs1    = f_rs1;
      Rs2    = f_rs2;
      Rd     = f_rd;
      imm    = f_imm;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ins_q       <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      if (!hazard) begin
        ins_q   <= ins_in[USED_W-1:0];
        valid_q <= ins_valid;
      end
    end
  end

endmodule

// File: tb/tb_issue_stage.sv
// Scoreboard bench for issue_stage: the driver pushes each instruction's expected
// issue (fields, relative issue cycle, stall count at issue) into a queue; the
// monitor pops and compares whenever the DUT issues a non-bubble.
module tb_issue_stage;

  localparam int unsigned PEND  = 5;
  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst;
  logic [31:0]      ins_in;
  logic             ins_valid;
  logic             fetch_stall;
  logic [2:0]       opcode;
  logic [4:0]       Rs1;
  logic [4:0]       Rs2;
  logic [4:0]       Rd;
  logic [11:0]      imm;
  logic [CNT_W-1:0] stall_cycles;

  issue_stage #(
    .PEND  (PEND),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ins_in       (ins_in),
    .ins_valid    (ins_valid),
    .fetch_stall  (fetch_stall),
    .opcode       (opcode),
    .Rs1          (Rs1),
    .Rs2          (Rs2),
    .Rd           (Rd),
    .imm          (imm),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         rel;
    logic [2:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [11:0] imm;
    int         stall;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   base  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [11:0] im);
    return {7'h55, im, rd, rs1, op};
  endfunction

  // Called at a negedge with fetch_stall low. Presents one instruction, lets it be
  // accepted, then counts the cycles it stalls before issuing.
  task automatic push(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [11:0] im, input logic valid, input int rel,
                      input int stall_tot, input int exp_wait);
    exp_t e;
    int   wt;
    ins_in    = mk(op, rd, rs1, im);
    ins_valid = valid;
    if (valid) begin
      e.rel = rel; e.op = op; e.rs1 = rs1; e.rs2 = im[4:0]; e.rd = rd; e.imm = im;
      e.stall = stall_tot;
      exp_q.push_back(e);
    end
    @(negedge clk);
    wt = 0;
    while (fetch_stall === 1'b1 && wt <= 50) begin
      @(negedge clk);
      wt++;
    end
    chk($sformatf("stall_len op%0d rd%0d", op, rd), 64'(wt), 64'(exp_wait));
  endtask

  task automatic idle(input int n);
    ins_in    = '0;
    ins_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every non-bubble issue must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst === 1'b1 && ({opcode, Rs1, Rs2, Rd, imm} != '0)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_issue: got op=%0d rs1=%0d rs2=%0d rd=%0d imm=%0h expected none",
                 opcode, Rs1, Rs2, Rd, imm);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("fields rel%0d", e.rel), 64'({opcode, Rs1, Rs2, Rd, imm}),
            64'({e.op, e.rs1, e.rs2, e.rd, e.imm}));
        chk($sformatf("issue_cycle rd%0d", e.rd), 64'(cyc - base), 64'(e.rel));
        chk($sformatf("stall_cycles rd%0d", e.rd), 64'(stall_cycles), 64'(e.stall));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with a valid instruction presented during reset.
    rst       = 1'b0;
    ins_in    = mk(3'd1, 5'd3, 5'd1, 12'd2);
    ins_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_fields", 64'({opcode, Rs1, Rs2, Rd, imm}), 64'd0);
    chk("reset_fetch_stall", 64'(fetch_stall), 64'd0);
    chk("reset_stall_cycles", 64'(stall_cycles), 64'd0);
    ins_valid = 1'b0;
    ins_in    = '0;
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Independent stream with one invalid slot.
    base = cyc;
    push(3'd1, 5'd1, 5'd2, 12'd3, 1'b1, 1, 0, 0);   // ADD r1 <- r2, r3
    push(3'd2, 5'd9, 5'd9, 12'd9, 1'b0, 0, 0, 0);   // not valid
    push(3'd2, 5'd4, 5'd5, 12'd6, 1'b1, 3, 0, 0);   // MUL r4 <- r5, r6
    push(3'd3, 5'd7, 5'd8, 12'd5, 1'b1, 4, 0, 0);   // ADDI r7 <- r8 + 5
    idle(PEND + 3);

    // Back-to-back dependency: 5 bubbles, issue in cycle 6 after producer.
    base = cyc;
    push(3'd1, 5'd3, 5'd1, 12'd2, 1'b1, 1, 0, 0);   // ADD r3 <- r1, r2
    push(3'd1, 5'd5, 5'd3, 12'd4, 1'b1, 7, 5, 5);   // ADD r5 <- r3, r4
    idle(PEND + 3);
    chk("stall_cycles_after_dep", 64'(stall_cycles), 64'd5);

    // ADDI whose imm low bits equal 3 does not check Rs2.
    base = cyc;
    push(3'd1, 5'd3, 5'd1, 12'd2,  1'b1, 1, 5, 0);  // ADD r3 <- r1, r2
    push(3'd3, 5'd9, 5'd1, 12'h803, 1'b1, 2, 5, 0); // ADDI r9 <- r1 + 0x803
    idle(PEND + 3);

    // R0 destination and NOP (opcode 4, Rd=3) never cause stalls.
    base = cyc;
    push(3'd1, 5'd0, 5'd1, 12'd2, 1'b1, 1, 5, 0);   // ADD r0 <- r1, r2
    push(3'd1, 5'd5, 5'd0, 12'd0, 1'b1, 2, 5, 0);   // ADD r5 <- r0, r0
    push(3'd4, 5'd3, 5'd1, 12'd0, 1'b1, 3, 5, 0);   // NOP with Rd field 3
    push(3'd1, 5'd6, 5'd3, 12'd3, 1'b1, 4, 5, 0);   // ADD r6 <- r3, r3
    idle(PEND + 3);

    // Two unrelated instructions between producer and consumer: PEND-2 stalls.
    base = cyc;
    push(3'd1, 5'd3,  5'd1,  12'd2,  1'b1, 1, 5, 0);
    push(3'd2, 5'd10, 5'd11, 12'd12, 1'b1, 2, 5, 0);
    push(3'd3, 5'd13, 5'd14, 12'd1,  1'b1, 3, 5, 0);
    push(3'd1, 5'd15, 5'd3,  12'd16, 1'b1, 7, 8, 3);
    idle(PEND + 3);

    // Both sources pending in different entries: wait for the younger (r4).
    base = cyc;
    push(3'd1, 5'd3, 5'd1, 12'd2, 1'b1, 1, 8, 0);   // ADD r3
    push(3'd1, 5'd4, 5'd1, 12'd2, 1'b1, 2, 8, 0);   // ADD r4
    push(3'd1, 5'd5, 5'd3, 12'd4, 1'b1, 8, 13, 5);  // ADD r5 <- r3, r4
    idle(PEND + 3);

    // Reset in the middle of a stall.
    base = cyc;
    push(3'd1, 5'd3, 5'd1, 12'd2, 1'b1, 1, 13, 0);  // ADD r3
    ins_in    = mk(3'd1, 5'd5, 5'd3, 12'd4);         // consumer of r3, left unchecked
    ins_valid = 1'b1;
    @(negedge clk);
    chk("mid_stall_fetch_stall", 64'(fetch_stall), 64'd1);
    #1 rst = 1'b0;
    #1;
    chk("rst_stall_fields", 64'({opcode, Rs1, Rs2, Rd, imm}), 64'd0);
    chk("rst_stall_fetch_stall", 64'(fetch_stall), 64'd0);
    chk("rst_stall_cycles", 64'(stall_cycles), 64'd0);
    ins_valid = 1'b0;
    ins_in    = '0;
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    base = cyc;
    push(3'd1, 5'd6, 5'd3, 12'd1, 1'b1, 1, 0, 0);   // ADD r6 <- r3, r1
    idle(PEND + 3);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/issue_stage.md
# issue_stage

In-order issue stage between instruction fetch and the decode/execute/write-back pipe. It holds one fetched instruction, splits it into fields, and checks its source registers against the destinations of instructions still in flight in the add and multiply pipes. On a read-after-write hazard it stalls fetch and sends bubbles downstream until the producer has written back. It also counts stall cycles for performance measurement.

## Interface
- `PEND`, default 5: cycles an issued destination stays pending. This is the pipe levels (4 for 32-bit) plus 1 write-back edge. It equals the bubble count between back-to-back dependent instructions.
- `CNT_W`, default 16: width of the stall counter.

- `clk` in 1: single clock; all state changes on posedge.
- `rst` in 1: asynchronous, active-low reset; takes effect on negedge, held while low.
- `ins_in` in 32: instruction from fetch.
- `ins_valid` in 1: `ins_in` is a real instruction this cycle.
- `fetch_stall` out 1: fetch must hold PC and `ins_in` (fetch start = start & ~fetch_stall).
- `opcode` out 3: issued opcode; 0 for a bubble.
- `Rs1`, `Rs2`, `Rd` out 5 each: issued register fields; 0 for a bubble.
- `imm` out 12: issued immediate; 0 for a bubble.
- `stall_cycles` out CNT_W: saturating count of stalled cycles.

## Operation
- Field split:
  - `opcode=ins[2:0]`
  - `Rs1=ins[7:3]`
  - `Rd=ins[12:8]`
  - `Rs2=ins[17:13]`
  - `imm=ins[24:13]` (`imm` overlaps `Rs2`).
- Opcode classes decode on `opcode[1:0]` only; `opcode[2]` is ignored.
  - 00: NOP.
  - 01: ADD; reads `Rs1` and `Rs2`.
  - 10: MUL; reads `Rs1` and `Rs2`.
  - 11: ADDI; reads `Rs1` only.
- `Rd=0` means no write-back. R0 is never pending and never causes a hazard.
- State:
  - Holding register `ins_q` with `valid_q`.
  - Scoreboard shift register `sb[0..PEND-1]` of 5-bit destinations.
  - `stall_cycles`.
- Hazard (combinational): `valid_q`, class is not NOP, and either:
  - `Rs1` is nonzero and equals some `sb[k]`, or
  - the class is ADD/MUL, `Rs2` is nonzero and equals some `sb[k]`.
- `fetch_stall` = hazard (combinational).
- Outputs are combinational from `ins_q`. When `!valid_q` or on a hazard they are forced to all-zero, i.e. a bubble.
- Every posedge:
  - `sb[0]` takes the issued `Rd`, or 0 for a bubble; `sb[k]` takes `sb[k-1]`. The scoreboard shifts every cycle, stalled or not, because the downstream pipe always advances.
  - No hazard: `ins_q` takes `ins_in` and `valid_q` takes `ins_valid`.
  - Hazard: `ins_q` and `valid_q` hold, `ins_in` is ignored, and `stall_cycles` increments, saturating at all-ones.
- A stalled instruction issues on the first cycle its matching entries have shifted out of `sb`.

## Timing
- Reset values, with `rst` low:
  - `sb` all 0, `valid_q` 0, `stall_cycles` 0.
  - All field outputs 0 (bubble); `fetch_stall` 0.
- Reset mid-stall drops the held instruction and clears pending state; no write-back is owed after reset.
- Issue latency: an instruction accepted at edge t drives the outputs in the cycle after t, if hazard-free.
- Dependent pair: consumer accepted one edge after the producer issues.
  - The consumer stalls exactly PEND cycles.
  - It issues in cycle PEND+1 after the producer's issue.
  - `stall_cycles` increases by PEND.
- A producer with `Rd=0`, or a NOP, never causes a stall.
- Multiple matches (both sources, or several `sb` entries): the stall lasts until the youngest match leaves `sb`.
- `ins_valid=0` while not stalled: the next cycle issues a bubble.

## Structure
- Shared package `isa_pkg`:
  - opcode class constants `OP_NOP`, `OP_ADD`, `OP_MUL`, `OP_ADDI`;
  - field bit positions;
  - `INS_W=32`, `REG_W=5`, `IMM_W=12`.
- One sub-module, `hazard_sb`:
  - holds the PEND-deep destination shift register;
  - has two compare ports (`Rs1`, `Rs2`) with enables;
  - outputs the hazard bit.
- `issue_stage` contains the holding register, field split, bubble muxing and counter.

## Test plan
- Independent stream, e.g. ADD r1←r2+r3, MUL r4←r5,r6, ADDI r7←r8+5, all valid every cycle → no `fetch_stall`; fields issue in order one per cycle; `stall_cycles`=0.
- ADD r3←r1+r2 then ADD r5←r3+r4 back-to-back → 5 bubble cycles, with `fetch_stall`=1 during them; consumer issues in the 6th cycle; `stall_cycles`=5.
- ADDI r9←r1+imm where the imm bits [17:13] equal 3, issued right after a write to r3 → no stall; the `Rs2` field is not checked for ADDI.
- ADD r0←r1+r2 then ADD r5←r0+r0 → no stall; NOP followed by anything → no stall.
- Producer r3, then 2 unrelated instructions, then a consumer of r3 → consumer stalls PEND-2=3 cycles.
- Drive `rst` low during a stall → outputs go to bubble immediately and `stall_cycles`=0. After release, a fresh instruction reading r3 issues with no stall.
